// File: rtl/chip_gpio_pkg.sv
// Shared register map and constants for the chip_core pad-bank GPIO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chip_gpio_pkg;

    // Register index, taken from addr[5:2]
    localparam logic [3:0] GPIO_IN      = 4'd0;
    localparam logic [3:0] GPIO_OUT     = 4'd1;
    localparam logic [3:0] GPIO_OE      = 4'd2;
    localparam logic [3:0] GPIO_IE      = 4'd3;
    localparam logic [3:0] GPIO_PU      = 4'd4;
    localparam logic [3:0] GPIO_PD      = 4'd5;
    localparam logic [3:0] GPIO_CS      = 4'd6;
    localparam logic [3:0] GPIO_SL      = 4'd7;
    localparam logic [3:0] GPIO_RISE_EN = 4'd8;
    localparam logic [3:0] GPIO_FALL_EN = 4'd9;
    localparam logic [3:0] GPIO_STATUS  = 4'd10;
    localparam logic [3:0] GPIO_OUT_SET = 4'd11;
    localparam logic [3:0] GPIO_OUT_CLR = 4'd12;

    // Per-bit reset values: everything off except input enable
    localparam logic RST_OFF = 1'b0;
    localparam logic RST_IE  = 1'b1;

    // Edge events are ignored until the priming counter reaches this value
    localparam logic [1:0] PRIME_DONE = 2'd3;

    // Number of 32-bit banks needed to cover n pads
    function automatic int num_banks(input int n);
        return (n + 31) / 32;
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Per-pad input path: 2-FF synchronizer, previous-value flop and gated edge detect.
// Latency: pin to sync_q 2 clocks; rise/fall are combinational from the flops.
// Backpressure: none, free-running every clock.
module gpio_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic rise_en,
    input  logic fall_en,
    output logic sync_q,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // Resynchronize the asynchronous pad level and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync_q = sync2;
    assign rise   = sync2 & ~prev & rise_en;
    assign fall   = ~sync2 & prev & fall_en;

endmodule

// File: rtl/chip_core_gpio.sv
// Core-side pad-bank controller: register file driving pad controls, synced inputs, edge IRQ.
// Latency: write commits at the req edge; ack/rdata one clock after req; irq one clock after STATUS.
// Backpressure: none, every request is accepted and acked next cycle; back-to-back allowed.
module chip_core_gpio
    import chip_gpio_pkg::*;
#(
    parameter int NUM_PADS = 37,
    parameter int ADDR_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                ack,
    output logic                irq,
    input  logic [NUM_PADS-1:0] bidir_in,
    output logic [NUM_PADS-1:0] bidir_out,
    output logic [NUM_PADS-1:0] bidir_oe,
    output logic [NUM_PADS-1:0] bidir_cs,
    output logic [NUM_PADS-1:0] bidir_sl,
    output logic [NUM_PADS-1:0] bidir_ie,
    output logic [NUM_PADS-1:0] bidir_pu,
    output logic [NUM_PADS-1:0] bidir_pd
);

    localparam int NB = num_banks(NUM_PADS);

    logic [3:0] idx;
    logic [1:0] bank;
    logic       wr;

    assign idx  = addr[5:2];
    assign bank = addr[1:0];
    assign wr   = req & we;

    logic [NUM_PADS-1:0] out_r, oe_r, ie_r, pu_r, pd_r, cs_r, sl_r;
    logic [NUM_PADS-1:0] rise_en_r, fall_en_r, status_r;
    logic [NUM_PADS-1:0] sync_q, rise_ev, fall_ev;
    logic [NUM_PADS-1:0] wr_sel, wr_bit, wr_val;
    logic [NUM_PADS-1:0] rd_vec;
    logic [31:0]         rd_word;
    logic [1:0]          prime_cnt;
    logic                primed;

    // Per-pad bank decode of the write data, and the input synchronizers
    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        localparam logic [1:0] PAD_BANK = 2'(i / 32);
        localparam int         PAD_BIT  = i % 32;

        assign wr_sel[i] = (bank == PAD_BANK);
        assign wr_bit[i] = wdata[PAD_BIT];

        gpio_in_sync u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .pin     (bidir_in[i]),
            .rise_en (rise_en_r[i]),
            .fall_en (fall_en_r[i]),
            .sync_q  (sync_q[i]),
            .rise    (rise_ev[i]),
            .fall    (fall_ev[i])
        );
    end

    // Bits of the addressed bank only; out-of-range banks select nothing
    assign wr_val = wr_bit & wr_sel;

    // Keep bits outside the addressed bank, replace bits inside it
    function automatic logic [NUM_PADS-1:0] merge(input logic [NUM_PADS-1:0] old_v,
                                                  input logic [NUM_PADS-1:0] sel,
                                                  input logic [NUM_PADS-1:0] val);
        return (old_v & ~sel) | val;
    endfunction

    // Select the full-width register named by the index; write-only and unmapped read 0
    always_comb begin
        rd_vec = '0;
        case (idx)
            GPIO_IN:      rd_vec = sync_q;
            GPIO_OUT:     rd_vec = out_r;
            GPIO_OE:      rd_vec = oe_r;
            GPIO_IE:      rd_vec = ie_r;
            GPIO_PU:      rd_vec = pu_r;
            GPIO_PD:      rd_vec = pd_r;
            GPIO_CS:      rd_vec = cs_r;
            GPIO_SL:      rd_vec = sl_r;
            GPIO_RISE_EN: rd_vec = rise_en_r;
            GPIO_FALL_EN: rd_vec = fall_en_r;
            GPIO_STATUS:  rd_vec = status_r;
            default:      rd_vec = '0;
        endcase
    end

    // Slice the addressed 32-bit bank out of the selected vector; missing pads read 0
    for (genvar j = 0; j < 32; j++) begin : g_rd
        logic [NB-1:0] hit;
        for (genvar b = 0; b < NB; b++) begin : g_bank
            if (b * 32 + j < NUM_PADS) begin : g_on
                assign hit[b] = rd_vec[b * 32 + j] & (bank == 2'(b));
            end else begin : g_off
                assign hit[b] = 1'b0;
            end
        end
        assign rd_word[j] = |hit;
    end

    // Pad control register file; OUT also has set/clear aliases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r     <= {NUM_PADS{RST_OFF}};
            oe_r      <= {NUM_PADS{RST_OFF}};
            ie_r      <= {NUM_PADS{RST_IE}};
            pu_r      <= {NUM_PADS{RST_OFF}};
            pd_r      <= {NUM_PADS{RST_OFF}};
            cs_r      <= {NUM_PADS{RST_OFF}};
            sl_r      <= {NUM_PADS{RST_OFF}};
            rise_en_r <= {NUM_PADS{RST_OFF}};
            fall_en_r <= {NUM_PADS{RST_OFF}};
        end else if (wr) begin
            case (idx)
                GPIO_OUT:     out_r     <= merge(out_r, wr_sel, wr_val);
                GPIO_OE:      oe_r      <= merge(oe_r, wr_sel, wr_val);
                GPIO_IE:      ie_r      <= merge(ie_r, wr_sel, wr_val);
                GPIO_PU:      pu_r      <= merge(pu_r, wr_sel, wr_val);
                GPIO_PD:      pd_r      <= merge(pd_r, wr_sel, wr_val);
                GPIO_CS:      cs_r      <= merge(cs_r, wr_sel, wr_val);
                GPIO_SL:      sl_r      <= merge(sl_r, wr_sel, wr_val);
                GPIO_RISE_EN: rise_en_r <= merge(rise_en_r, wr_sel, wr_val);
                GPIO_FALL_EN: fall_en_r <= merge(fall_en_r, wr_sel, wr_val);
                GPIO_OUT_SET: out_r     <= out_r | wr_val;
                GPIO_OUT_CLR: out_r     <= out_r & ~wr_val;
                default:      ;
            endcase
        end
    end

    // Priming counter holds off edge events while the synchronizers fill after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= 2'd0;
        end else if (prime_cnt != PRIME_DONE) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    assign primed = (prime_cnt == PRIME_DONE);

    // Sticky event status: W1C clears, a same-cycle event re-sets (set wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= '0;
        end else begin
            status_r <= (status_r & ~((wr && idx == GPIO_STATUS) ? wr_val : '0))
                      | (primed ? (rise_ev | fall_ev) : '0);
        end
    end

    // Level interrupt from any pending status bit whose source is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status_r & (rise_en_r | fall_en_r));
        end
    end

    // Bus response: ack every request one cycle later, read data only for reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= req;
            rdata <= (req && !we) ? rd_word : '0;
        end
    end

    assign bidir_out = out_r;
    assign bidir_oe  = oe_r;
    assign bidir_cs  = cs_r;
    assign bidir_sl  = sl_r;
    assign bidir_ie  = ie_r;
    assign bidir_pu  = pu_r;
    assign bidir_pd  = pd_r & ~pu_r;

endmodule

// File: tb/tb_chip_core_gpio.sv
module tb_chip_core_gpio;
    import chip_gpio_pkg::*;

    localparam int NP = 37;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [5:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          irq;
    logic [NP-1:0] bidir_in;
    logic [NP-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

    int total = 0;
    int bad   = 0;

    logic [31:0] d;
    logic        a;

    chip_core_gpio #(.NUM_PADS(NP), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .irq       (irq),
        .bidir_in  (bidir_in),
        .bidir_out (bidir_out),
        .bidir_oe  (bidir_oe),
        .bidir_cs  (bidir_cs),
        .bidir_sl  (bidir_sl),
        .bidir_ie  (bidir_ie),
        .bidir_pu  (bidir_pu),
        .bidir_pd  (bidir_pd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a negedge; the write commits at the next posedge, returns at the negedge after
    task automatic bus_wr(input logic [3:0] idx, input logic [1:0] bk, input logic [31:0] dat);
        req = 1'b1; we = 1'b1; addr = {idx, bk}; wdata = dat;
        @(negedge clk);
        req = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_rd(input logic [3:0] idx, input logic [1:0] bk,
                          output logic [31:0] dat, output logic got_ack);
        req = 1'b1; we = 1'b0; addr = {idx, bk};
        @(negedge clk);
        req = 1'b0;
        dat = rdata;
        got_ack = ack;
    endtask

    task automatic test_reset();
        bus_wr(GPIO_OE, 2'd0, 32'h0000_00FF);
        total++; if (bidir_oe[7:0] !== 8'hFF) begin bad++; $display("FAIL rst_pre_oe got=%h want=ff", bidir_oe[7:0]); end
        req = 1'b1; we = 1'b0; addr = {GPIO_IE, 2'd0};
        @(posedge clk); #1;
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rst_pre_ack got=%b want=1", ack); end
        #1 rst_n = 1'b0;
        #1 req = 1'b0;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", ack); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        total++; if (bidir_oe !== '0) begin bad++; $display("FAIL rst_oe got=%h want=0", bidir_oe); end
        total++; if (bidir_ie !== {NP{1'b1}}) begin bad++; $display("FAIL rst_ie got=%h want=all1", bidir_ie); end
        total++; if (bidir_out !== '0 || bidir_pu !== '0 || bidir_pd !== '0 || bidir_cs !== '0 || bidir_sl !== '0)
            begin bad++; $display("FAIL rst_ctl got out=%h pu=%h pd=%h cs=%h sl=%h want=0", bidir_out, bidir_pu, bidir_pd, bidir_cs, bidir_sl); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(GPIO_IE, 2'd0, d, a);
        total++; if (d !== 32'hFFFF_FFFF || a !== 1'b1) begin bad++; $display("FAIL rd_ie_b0 got=%h ack=%b want=ffffffff ack=1", d, a); end
        bus_rd(GPIO_IE, 2'd1, d, a);
        total++; if (d !== 32'h0000_001F) begin bad++; $display("FAIL rd_ie_b1 got=%h want=0000001f", d); end
    endtask

    task automatic test_out();
        bus_wr(GPIO_OE, 2'd0, 32'h0000_000F);
        total++; if (bidir_oe[3:0] !== 4'hF) begin bad++; $display("FAIL oe_pad got=%h want=f", bidir_oe[3:0]); end
        bus_wr(GPIO_OUT, 2'd0, 32'h0000_0005);
        total++; if (bidir_out[3:0] !== 4'h5) begin bad++; $display("FAIL out_pad got=%h want=5", bidir_out[3:0]); end
        bus_wr(GPIO_OUT_SET, 2'd0, 32'h0000_0002);
        total++; if (bidir_out[3:0] !== 4'h7) begin bad++; $display("FAIL out_set got=%h want=7", bidir_out[3:0]); end
        bus_wr(GPIO_OUT_CLR, 2'd0, 32'h0000_0001);
        total++; if (bidir_out[3:0] !== 4'h6) begin bad++; $display("FAIL out_clr got=%h want=6", bidir_out[3:0]); end
        bus_rd(GPIO_OUT, 2'd0, d, a);
        total++; if (d !== 32'h0000_0006) begin bad++; $display("FAIL rd_out got=%h want=00000006", d); end
        bus_wr(GPIO_OE, 2'd1, 32'hFFFF_FFFF);
        bus_rd(GPIO_OE, 2'd1, d, a);
        total++; if (d !== 32'h0000_001F) begin bad++; $display("FAIL rd_oe_b1 got=%h want=0000001f", d); end
        total++; if (bidir_oe[36:32] !== 5'h1F || bidir_oe[31:4] !== '0)
            begin bad++; $display("FAIL oe_b1_pad got=%h want=1f0000000f", bidir_oe); end
    endtask

    task automatic test_rise_irq();
        bus_wr(GPIO_RISE_EN, 2'd1, 32'h0000_0010);
        step(); step();
        bidir_in[36] = 1'b1;
        step();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rise_irq_early got=%b want=0", irq); end
        step();
        bus_rd(GPIO_IN, 2'd1, d, a);
        total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL rise_in got=%h want=00000010", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rise_irq_3 got=%b want=0", irq); end
        bus_rd(GPIO_STATUS, 2'd1, d, a);
        total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL rise_status got=%h want=00000010", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rise_irq_4 got=%b want=1", irq); end
        bus_wr(GPIO_STATUS, 2'd1, 32'h0000_0010);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b want=1", irq); end
        step();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop got=%b want=0", irq); end
        bus_rd(GPIO_STATUS, 2'd1, d, a);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_status got=%h want=0", d); end
    endtask

    task automatic test_w1c_collision();
        bus_wr(GPIO_FALL_EN, 2'd1, 32'h0000_0010);
        bidir_in[36] = 1'b0;
        step(); step();
        bus_wr(GPIO_STATUS, 2'd1, 32'h0000_0010);
        bus_rd(GPIO_STATUS, 2'd1, d, a);
        total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL collide_status got=%h want=00000010", d); end
        bus_wr(GPIO_STATUS, 2'd1, 32'h0000_0010);
        bus_rd(GPIO_STATUS, 2'd1, d, a);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL collide_clear got=%h want=0", d); end
        bus_wr(GPIO_FALL_EN, 2'd1, 32'h0);
        bus_wr(GPIO_RISE_EN, 2'd1, 32'h0);
    endtask

    task automatic test_pull_unmapped();
        bus_wr(GPIO_PU, 2'd0, 32'h1);
        bus_wr(GPIO_PD, 2'd0, 32'h1);
        total++; if (bidir_pu[0] !== 1'b1 || bidir_pd[0] !== 1'b0)
            begin bad++; $display("FAIL pull_conflict got pu=%b pd=%b want pu=1 pd=0", bidir_pu[0], bidir_pd[0]); end
        bus_rd(GPIO_PD, 2'd0, d, a);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL rd_pd got=%h want=00000001", d); end
        bus_wr(GPIO_PU, 2'd0, 32'h0);
        total++; if (bidir_pd[0] !== 1'b1) begin bad++; $display("FAIL pd_alone got=%b want=1", bidir_pd[0]); end
        bus_rd(4'd15, 2'd0, d, a);
        total++; if (d !== 32'h0 || a !== 1'b1) begin bad++; $display("FAIL unmapped got=%h ack=%b want=0 ack=1", d, a); end
        bus_rd(GPIO_OUT_SET, 2'd0, d, a);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_out_set got=%h want=0", d); end
        bus_rd(GPIO_OE, 2'd2, d, a);
        total++; if (d !== 32'h0 || a !== 1'b1) begin bad++; $display("FAIL rd_bank2 got=%h ack=%b want=0 ack=1", d, a); end
        bus_wr(GPIO_OUT, 2'd2, 32'hFFFF_FFFF);
        bus_rd(GPIO_OUT, 2'd0, d, a);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL wr_bank2_drop got=%h want=00000006", d); end
    endtask

    task automatic test_prime_back_to_back();
        logic [3:0]  ridx [6] = '{GPIO_IE, GPIO_IE, GPIO_IN, GPIO_IN, GPIO_OE, GPIO_OUT};
        logic [1:0]  rbk  [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
        logic [31:0] rexp [6] = '{32'hFFFF_FFFF, 32'h1F, 32'hFFFF_FFFF, 32'h1F, 32'h0, 32'h0};
        bidir_in = '1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus_wr(GPIO_RISE_EN, 2'd0, 32'hFFFF_FFFF);
        bus_wr(GPIO_RISE_EN, 2'd1, 32'hFFFF_FFFF);
        repeat (4) step();
        bus_rd(GPIO_STATUS, 2'd0, d, a);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL prime_status_b0 got=%h want=0", d); end
        bus_rd(GPIO_STATUS, 2'd1, d, a);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL prime_status_b1 got=%h want=0", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL prime_irq got=%b want=0", irq); end
        for (int k = 0; k < 6; k++) begin
            req = 1'b1; we = 1'b0; addr = {ridx[k], rbk[k]};
            @(negedge clk);
            total++; if (ack !== 1'b1 || rdata !== rexp[k])
                begin bad++; $display("FAIL b2b_%0d got=%h ack=%b want=%h ack=1", k, rdata, ack, rexp[k]); end
        end
        req = 1'b0;
        step();
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_end got=%b want=0", ack); end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; bidir_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        test_reset();
        test_out();
        test_rise_irq();
        test_w1c_collision();
        test_pull_unmapped();
        test_prime_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
